// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: address/data widths and
// types, FSM state encoding, grant encoding and a small grant helper.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;

  // Big-endian bit numbering inherited from the original bus definition.
  typedef logic [15:15+ADDR_W-1] addr_t;
  typedef logic [0:DATA_W-1]     data_t;

  // FSM state encoding (kept as plain constants for legacy tools).
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_IOP = 1'b1
  } gnt_t;

  // The port that did not receive the given grant.
  function automatic gnt_t gnt_other(input gnt_t g);
    gnt_t r;
    if (g == GNT_CPU) begin
      r = GNT_IOP;
    end else begin
      r = GNT_CPU;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU port, I/O-processor port, read-data return and memory
// command bus of the arbiter.
//   slave  : arbiter view (requests/memory data in, acks/commands out)
//   master : requester + memory view (the opposite directions)
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic  cpu_req;
  logic  cpu_we;
  addr_t cpu_addr;
  data_t cpu_wdata;
  logic  cpu_lock;
  logic  cpu_ack;

  logic  iop_req;
  logic  iop_we;
  addr_t iop_addr;
  data_t iop_wdata;
  logic  iop_ack;

  data_t rdata;
  logic  busy;

  logic  mem_en;
  logic  mem_we;
  addr_t mem_addr;
  data_t mem_wdata;
  data_t mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  iop_req, iop_we, iop_addr, iop_wdata,
    input  mem_rdata,
    output cpu_ack, iop_ack, rdata, busy,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output iop_req, iop_we, iop_addr, iop_wdata,
    output mem_rdata,
    input  cpu_ack, iop_ack, rdata, busy,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// ---------------------------------------------------------------------------
// arb_rr2
// Two-way round-robin pick between CPU and IOP.
//   req_cpu, req_iop : pending requests
//   last_gnt         : port granted most recently
//   lock             : CPU holds exclusive ownership (only CPU eligible)
//   gnt_valid        : a winner exists this cycle
//   gnt              : the winner
// Purely combinational.
// ---------------------------------------------------------------------------
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_iop,
  input  gnt_t last_gnt,
  input  logic lock,
  output logic gnt_valid,
  output gnt_t gnt
);

  // Winner selection: lock overrides, tie goes to the port not granted last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = GNT_CPU;
    if (lock) begin
      // While locked the IOP is not eligible even if the CPU is idle.
      gnt_valid = req_cpu;
      gnt       = GNT_CPU;
    end else if (req_cpu && req_iop) begin
      gnt_valid = 1'b1;
      gnt       = gnt_other(last_gnt);
    end else if (req_cpu) begin
      gnt_valid = 1'b1;
      gnt       = GNT_CPU;
    end else if (req_iop) begin
      gnt_valid = 1'b1;
      gnt       = GNT_IOP;
    end else begin
      gnt_valid = 1'b0;
      gnt       = GNT_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a CPU port and an I/O-processor port onto a single memory with
// WAIT_STATES extra cycles per access. Sequence per access:
// IDLE (pick + latch) -> ACCESS (WAIT_STATES+1 cycles, mem_en high)
// -> DONE (one-cycle ack to the winner) -> IDLE.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (request ports, acks, rdata, busy, memory bus)
// Parameter:
//   WAIT_STATES : extra memory cycles per access, 0..7
// Build option:
//   MEM_ARBITER_LOCK_EN : when defined, a CPU access carrying cpu_lock=1
//   keeps the CPU as the only eligible winner until a CPU access completes
//   with cpu_lock=0. When undefined, cpu_lock is ignored.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES = 2
)
(
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic [2:0] cnt_r;
  gnt_t       win_r;
  gnt_t       last_gnt_r;
  gnt_t       gnt_s;
  logic       gnt_valid_s;
  logic       lock_q_s;
  logic       final_s;

  logic       lat_we_r;
  addr_t      lat_addr_r;
  data_t      lat_wdata_r;

  logic       sel_we_s;
  addr_t      sel_addr_s;
  data_t      sel_wdata_s;

  logic       cpu_ack_r;
  logic       iop_ack_r;
  logic       busy_r;
  data_t      rdata_r;
  logic       mem_en_r;
  logic       mem_we_r;
  addr_t      mem_addr_r;
  data_t      mem_wdata_r;

  arb_rr2 u_rr (
    .req_cpu   (bus.cpu_req),
    .req_iop   (bus.iop_req),
    .last_gnt  (last_gnt_r),
    .lock      (lock_q_s),
    .gnt_valid (gnt_valid_s),
    .gnt       (gnt_s)
  );

  // Last cycle of an access: the counter has run down inside ACCESS.
  assign final_s = (state_r == ST_ACCESS) && (cnt_r == 3'd0);

  // Request fields of the port that wins this cycle.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    if (gnt_s == GNT_IOP) begin
      sel_we_s    = bus.iop_we;
      sel_addr_s  = bus.iop_addr;
      sel_wdata_s = bus.iop_wdata;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, wait counter, latched request, winner history and read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      win_r       <= GNT_CPU;
      last_gnt_r  <= GNT_IOP;
      lat_we_r    <= 1'b0;
      lat_addr_r  <= '0;
      lat_wdata_r <= '0;
      rdata_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (gnt_valid_s) begin
            win_r       <= gnt_s;
            cnt_r       <= WS_LOAD;
            lat_we_r    <= sel_we_s;
            lat_addr_r  <= sel_addr_s;
            lat_wdata_r <= sel_wdata_s;
          end
        end
        ST_ACCESS: begin
          if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
          end else if (!lat_we_r) begin
            rdata_r <= bus.mem_rdata;
          end
        end
        ST_DONE: last_gnt_r <= win_r;
        default: cnt_r <= 3'd0;
      endcase
    end
  end

  // Registered outputs: acks, busy and the memory command.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_ack_r   <= 1'b0;
      iop_ack_r   <= 1'b0;
      busy_r      <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      cpu_ack_r <= final_s && (win_r == GNT_CPU);
      iop_ack_r <= final_s && (win_r == GNT_IOP);
      busy_r    <= (state_nxt_s != ST_IDLE);
      if (state_nxt_s == ST_ACCESS) begin
        mem_en_r <= 1'b1;
        // On entry the latch is being loaded this same edge, so take the
        // winner's fields directly; afterwards replay the latch.
        if (state_r == ST_IDLE) begin
          mem_we_r    <= sel_we_s;
          mem_addr_r  <= sel_addr_s;
          mem_wdata_r <= sel_wdata_s;
        end else begin
          mem_we_r    <= lat_we_r;
          mem_addr_r  <= lat_addr_r;
          mem_wdata_r <= lat_wdata_r;
        end
      end else begin
        mem_en_r    <= 1'b0;
        mem_we_r    <= 1'b0;
        mem_addr_r  <= '0;
        mem_wdata_r <= '0;
      end
    end
  end

`ifdef MEM_ARBITER_LOCK_EN
  logic lock_r;
  logic lat_lock_r;

  // Lock bit is captured with the request and takes effect when it completes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lock_r     <= 1'b0;
      lat_lock_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && gnt_valid_s) begin
        lat_lock_r <= (gnt_s == GNT_CPU) && bus.cpu_lock;
      end
      if ((state_r == ST_DONE) && (win_r == GNT_CPU)) begin
        lock_r <= lat_lock_r;
      end
    end
  end

  assign lock_q_s = lock_r;
`else
  assign lock_q_s = 1'b0;
`endif

  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.iop_ack   = iop_ack_r;
  assign bus.busy      = busy_r;
  assign bus.rdata     = rdata_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters (WAIT_STATES=2 and WAIT_STATES=0) behind one stimulus source;
// dsel picks which one receives requests and is observed. A memory responder
// stores writes and returns data only in the final ACCESS cycle (inverted
// before that). Expected values come from a table and from a reference
// model: latency/enable counts from the timing rule, read data from a
// reference memory, grant order from the round-robin/lock rules.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if bus2();
  mem_arbiter_if bus0();

  mem_arbiter #(.WAIT_STATES(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));
  mem_arbiter #(.WAIT_STATES(0)) u_dut0 (.clock(clock), .reset(reset), .bus(bus0));

  // Stimulus variables
  logic        dsel = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_lock = 1'b0;
  logic        iop_req = 1'b0, iop_we = 1'b0;
  logic [16:0] cpu_addr = 17'd0, iop_addr = 17'd0;
  logic [31:0] cpu_wdata = 32'd0, iop_wdata = 32'd0;
  logic        force_en = 1'b0;
  logic [31:0] force_val = 32'd0;

  assign bus2.cpu_req   = cpu_req & ~dsel;
  assign bus0.cpu_req   = cpu_req & dsel;
  assign bus2.iop_req   = iop_req & ~dsel;
  assign bus0.iop_req   = iop_req & dsel;
  assign bus2.cpu_we    = cpu_we;    assign bus0.cpu_we    = cpu_we;
  assign bus2.cpu_lock  = cpu_lock;  assign bus0.cpu_lock  = cpu_lock;
  assign bus2.cpu_addr  = cpu_addr;  assign bus0.cpu_addr  = cpu_addr;
  assign bus2.cpu_wdata = cpu_wdata; assign bus0.cpu_wdata = cpu_wdata;
  assign bus2.iop_we    = iop_we;    assign bus0.iop_we    = iop_we;
  assign bus2.iop_addr  = iop_addr;  assign bus0.iop_addr  = iop_addr;
  assign bus2.iop_wdata = iop_wdata; assign bus0.iop_wdata = iop_wdata;

  // Background memory contents for never-written words.
  function automatic logic [31:0] dflt(input logic [16:0] a);
    return 32'h6B3D_0000 ^ ({15'd0, a} * 32'd40503);
  endfunction

  // Memory responder: stores value^dflt so a zeroed array means "default".
  bit [31:0] resp_mem [0:262143];
  int        en_cnt2 = 0, en_cnt0 = 0;
  logic [31:0] rd2, rd0;

  always @(posedge clock) begin
    if (bus2.mem_en) begin
      if (bus2.mem_we) resp_mem[{1'b0, bus2.mem_addr}] <= bus2.mem_wdata ^ dflt(bus2.mem_addr);
      en_cnt2 <= en_cnt2 + 1;
    end else begin
      en_cnt2 <= 0;
    end
    if (bus0.mem_en) begin
      if (bus0.mem_we) resp_mem[{1'b1, bus0.mem_addr}] <= bus0.mem_wdata ^ dflt(bus0.mem_addr);
      en_cnt0 <= en_cnt0 + 1;
    end else begin
      en_cnt0 <= 0;
    end
  end

  always_comb begin
    rd2 = force_en ? force_val : (resp_mem[{1'b0, bus2.mem_addr}] ^ dflt(bus2.mem_addr));
    rd0 = force_en ? force_val : (resp_mem[{1'b1, bus0.mem_addr}] ^ dflt(bus0.mem_addr));
    bus2.mem_rdata = (en_cnt2 == 2) ? rd2 : ~rd2;
    bus0.mem_rdata = (en_cnt0 == 0) ? rd0 : ~rd0;
  end

  // Observed DUT
  logic        o_cpu_ack, o_iop_ack, o_busy, o_en, o_we;
  logic [16:0] o_addr;
  logic [31:0] o_wdata, o_rdata;
  assign o_cpu_ack = dsel ? bus0.cpu_ack   : bus2.cpu_ack;
  assign o_iop_ack = dsel ? bus0.iop_ack   : bus2.iop_ack;
  assign o_busy    = dsel ? bus0.busy      : bus2.busy;
  assign o_en      = dsel ? bus0.mem_en    : bus2.mem_en;
  assign o_we      = dsel ? bus0.mem_we    : bus2.mem_we;
  assign o_addr    = dsel ? bus0.mem_addr  : bus2.mem_addr;
  assign o_wdata   = dsel ? bus0.mem_wdata : bus2.mem_wdata;
  assign o_rdata   = dsel ? bus0.rdata     : bus2.rdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [logic [17:0]];
  logic [31:0] last_rd [2];

  function automatic logic [31:0] ref_read(input bit s, input logic [16:0] a);
    if (ref_mem.exists({s, a})) return ref_mem[{s, a}];
    return dflt(a);
  endfunction

  // One single-port access on the selected DUT, fully checked.
  task automatic txn(input string nm, input bit s, input bit port, input bit we,
                     input logic [16:0] a, input logic [31:0] wd, input bit drop,
                     input int exp_lat, input int exp_en, input logic [31:0] exp_rd);
    int lat = 0;
    int en = 0;
    bit bad = 1'b0;
    bit done = 1'b0;
    dsel = s;
    if (port == 1'b0) begin
      cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_lock = 1'b0; cpu_req = 1'b1;
    end else begin
      iop_we = we; iop_addr = a; iop_wdata = wd; iop_req = 1'b1;
    end
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clock);
      if (!o_busy) bad = 1'b1;
      if (o_cpu_ack && o_iop_ack) bad = 1'b1;
      if (o_en) begin
        en++;
        if (o_we !== we || o_addr !== a) bad = 1'b1;
        if (we && o_wdata !== wd) bad = 1'b1;
      end
      if (drop && k == 1) begin cpu_req = 1'b0; iop_req = 1'b0; end
      if ((port == 1'b0 && o_iop_ack) || (port == 1'b1 && o_cpu_ack)) bad = 1'b1;
      if ((port == 1'b0) ? o_cpu_ack : o_iop_ack) begin
        lat = k;
        done = 1'b1;
        chk({nm, "_rdata"}, o_rdata, exp_rd);
        cpu_req = 1'b0; iop_req = 1'b0;
      end
    end
    chk({nm, "_ack_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_mem_en_cycles"}, 32'(en), 32'(exp_en));
    chk({nm, "_bus_ok"}, 32'(bad), 32'd0);
    @(negedge clock);
    chk({nm, "_idle_outputs"}, {o_busy, o_en, o_we, o_cpu_ack, o_iop_ack, o_addr}, 32'd0);
    chk({nm, "_idle_wdata"}, o_wdata, 32'd0);
    if (we) ref_mem[{s, a}] = wd;
    else last_rd[s] = exp_rd;
  endtask

  typedef struct {
    bit          s;
    bit          port;
    bit          we;
    logic [16:0] a;
    logic [31:0] wd;
    bit          frc;
    logic [31:0] fv;
    bit          drop;
    int          lat;
    int          en;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [7];

  initial begin
    gnt_t           exp_q [$];
    gnt_t           got_q [$];
    int             cyc_q [$];
    gnt_t           last;
    bit             lockact;
    int             cpu_left, iop_left, fidx, ovl, cpu_done, iop_done;
    bit             flags [3];

    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;

    // Directed table: expected latency/enable/rdata written out as constants.
    vt[0] = '{s:1'b0, port:1'b0, we:1'b0, a:17'h00100, wd:32'd0, frc:1'b1, fv:32'hDEADBEEF, drop:1'b0, lat:4, en:3, rd:32'hDEADBEEF};
    vt[1] = '{s:1'b0, port:1'b1, we:1'b1, a:17'h1FFFF, wd:32'h12345678, frc:1'b0, fv:32'd0, drop:1'b0, lat:4, en:3, rd:32'hDEADBEEF};
    vt[2] = '{s:1'b0, port:1'b0, we:1'b0, a:17'h1FFFF, wd:32'd0, frc:1'b0, fv:32'd0, drop:1'b0, lat:4, en:3, rd:32'h12345678};
    vt[3] = '{s:1'b0, port:1'b1, we:1'b0, a:17'h1FFFF, wd:32'd0, frc:1'b0, fv:32'd0, drop:1'b1, lat:4, en:3, rd:32'h12345678};
    vt[4] = '{s:1'b1, port:1'b0, we:1'b0, a:17'h00040, wd:32'd0, frc:1'b1, fv:32'hCAFEF00D, drop:1'b0, lat:2, en:1, rd:32'hCAFEF00D};
    vt[5] = '{s:1'b1, port:1'b1, we:1'b1, a:17'h00041, wd:32'hA5A55A5A, frc:1'b0, fv:32'd0, drop:1'b0, lat:2, en:1, rd:32'hCAFEF00D};
    vt[6] = '{s:1'b1, port:1'b0, we:1'b0, a:17'h00041, wd:32'd0, frc:1'b0, fv:32'd0, drop:1'b1, lat:2, en:1, rd:32'hA5A55A5A};

    // Reset state of both instances
    repeat (2) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      #1;
      chk($sformatf("reset_ctl_d%0d", d), {o_busy, o_en, o_we, o_cpu_ack, o_iop_ack}, 32'd0);
      chk($sformatf("reset_addr_d%0d", d), 32'(o_addr), 32'd0);
      chk($sformatf("reset_wdata_d%0d", d), o_wdata, 32'd0);
      chk($sformatf("reset_rdata_d%0d", d), o_rdata, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      force_en = vt[i].frc;
      force_val = vt[i].fv;
      txn($sformatf("vec%0d", i), vt[i].s, vt[i].port, vt[i].we, vt[i].a, vt[i].wd,
          vt[i].drop, vt[i].lat, vt[i].en, vt[i].rd);
      force_en = 1'b0;
    end

    // Randomized accesses against the reference memory
    for (int i = 0; i < 24; i++) begin
      bit          s, port, we, drop;
      logic [16:0] a;
      logic [31:0] wd, exp_rd;
      int          ws;
      s    = 1'($urandom_range(0, 1));
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      drop = ($urandom_range(0, 3) == 0);
      a    = ($urandom_range(0, 1) == 1) ? (17'h1FFF8 + 17'($urandom_range(0, 7)))
                                         : 17'($urandom_range(0, 7));
      wd   = $urandom;
      ws   = s ? 0 : 2;
      exp_rd = we ? last_rd[s] : ref_read(s, a);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      txn($sformatf("rnd%0d", i), s, port, we, a, wd, drop, ws + 2, ws + 1, exp_rd);
    end

    // Reset during the second ACCESS cycle abandons the access
    dsel = 1'b0;
    cpu_we = 1'b0; cpu_addr = 17'h00200; cpu_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("abort_in_access", {o_busy, o_en}, 32'h3);
    reset = 1'b0;
    #1;
    chk("abort_busy_now", 32'(o_busy), 32'd0);
    chk("abort_mem_en_now", 32'(o_en), 32'd0);
    cpu_req = 1'b0;
    ovl = 0;
    repeat (3) begin
      @(negedge clock);
      if (o_cpu_ack || o_iop_ack) ovl++;
    end
    chk("abort_no_ack", 32'(ovl), 32'd0);
    chk("abort_rdata_cleared", o_rdata, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    reset = 1'b1;
    @(negedge clock);
    txn("after_abort", 1'b0, 1'b0, 1'b0, 17'h00200, 32'd0, 1'b0, 4, 3, ref_read(1'b0, 17'h00200));

    // Both ports held from reset: round-robin starting with the CPU
    reset = 1'b0;
    dsel = 1'b0;
    cpu_we = 1'b0; iop_we = 1'b0; cpu_lock = 1'b0;
    cpu_req = 1'b1; iop_req = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    last = GNT_IOP;
    for (int i = 0; i < 4; i++) begin
      last = (last == GNT_CPU) ? GNT_IOP : GNT_CPU;
      exp_q.push_back(last);
    end
    got_q.delete(); cyc_q.delete(); ovl = 0;
    for (int k = 0; k < 60 && got_q.size() < 4; k++) begin
      @(negedge clock);
      if (o_cpu_ack && o_iop_ack) ovl++;
      if (o_cpu_ack) begin got_q.push_back(GNT_CPU); cyc_q.push_back(k); end
      else if (o_iop_ack) begin got_q.push_back(GNT_IOP); cyc_q.push_back(k); end
    end
    cpu_req = 1'b0; iop_req = 1'b0;
    chk("rr_ack_count", 32'(got_q.size()), 32'd4);
    chk("rr_ack_overlap", 32'(ovl), 32'd0);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(cyc_q[i] - cyc_q[i-1]), 32'd5);
    end
    repeat (4) @(negedge clock);

    // CPU lock sequence with the IOP waiting
    flags[0] = 1'b1; flags[1] = 1'b1; flags[2] = 1'b0;
    exp_q.delete();
    last = GNT_IOP; lockact = 1'b0; cpu_left = 3; iop_left = 1; fidx = 0;
    while (cpu_left > 0 || iop_left > 0) begin
      gnt_t g;
      if (lockact) g = GNT_CPU;
      else if (cpu_left > 0 && iop_left > 0) g = (last == GNT_CPU) ? GNT_IOP : GNT_CPU;
      else g = (cpu_left > 0) ? GNT_CPU : GNT_IOP;
      exp_q.push_back(g);
      last = g;
      if (g == GNT_CPU) begin
`ifdef MEM_ARBITER_LOCK_EN
        lockact = flags[fidx];
`else
        lockact = 1'b0;
`endif
        fidx++;
        cpu_left--;
      end else begin
        iop_left--;
      end
    end
    reset = 1'b0;
    cpu_lock = flags[0];
    cpu_req = 1'b1; iop_req = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    got_q.delete(); cpu_done = 0; iop_done = 0; ovl = 0;
    for (int k = 0; k < 100 && !(cpu_done == 3 && iop_done == 1); k++) begin
      @(negedge clock);
      if (o_cpu_ack && o_iop_ack) ovl++;
      if (o_cpu_ack) begin
        got_q.push_back(GNT_CPU);
        cpu_done++;
        if (cpu_done < 3) cpu_lock = flags[cpu_done];
        else begin cpu_req = 1'b0; cpu_lock = 1'b0; end
      end else if (o_iop_ack) begin
        got_q.push_back(GNT_IOP);
        iop_done++;
        iop_req = 1'b0;
      end
    end
    cpu_req = 1'b0; iop_req = 1'b0;
    chk("lock_ack_count", 32'(got_q.size()), 32'd4);
    chk("lock_ack_overlap", 32'(ovl), 32'd0);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("lock_grant%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    repeat (3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
